// File: rtl/gate_tt_pkg.sv
// Shared types and constants for the gate truth-table checker.
// Default truth tables are indexed by stim: bit i is the expected gate output for vector i.
package gate_tt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    FIN    = 2'd3
  } state_t;

  localparam int DEF_N_IN = 2;
  localparam int NUM_VEC  = 1 << DEF_N_IN;
  localparam int CNT_W    = DEF_N_IN + 1;

  localparam logic [3:0] OR_TT  = 4'b1110;
  localparam logic [3:0] AND_TT = 4'b1000;
  localparam logic [3:0] XOR_TT = 4'b0110;

  function automatic int num_vec(input int n_in);
    return 1 << n_in;
  endfunction

  function automatic int cnt_w(input int n_in);
    return n_in + 1;
  endfunction

endpackage

// File: rtl/gate_tt_checker_settle_timer.sv
// Settle-time down-counter: load to LOAD_VAL, count down while enabled,
// expired when the count reaches zero.
module settle_timer #(
  parameter int W        = 2,
  parameter int LOAD_VAL = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count_en,
  output logic expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(LOAD_VAL);
    end else if (count_en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/gate_tt_checker.sv
// Exhaustive truth-table checker for small combinational gates.
// Optional build macro GATE_TT_STOP_ON_FAIL_EN ends a run at the first mismatch.
//
// state  | meaning
// IDLE   | waiting for start; results of the last run held
// DRIVE  | stim applied, waiting SETTLE_CYC cycles for the gate to settle
// SAMPLE | resp compared against EXP_TT[stim]; advance or finish
// FIN    | one cycle: done pulse, pass valid, busy low
module gate_tt_checker
  import gate_tt_pkg::*;
#(
  parameter int                      N_IN       = 2,
  parameter logic [(2**N_IN)-1:0]    EXP_TT     = OR_TT,
  parameter int                      SETTLE_CYC = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            resp,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] fail_idx
);

  localparam int N_VEC = num_vec(N_IN);
  localparam int ERR_W = cnt_w(N_IN);
  localparam int TW    = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);

`ifdef GATE_TT_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  state_t state;
  logic   mismatch;
  logic   last_vec;
  logic   finish_now;
  logic   tmr_load;
  logic   tmr_en;
  logic   tmr_expired;

  assign mismatch   = (resp != EXP_TT[stim]);
  assign last_vec   = &stim;
  assign finish_now = last_vec || (STOP_ON_FAIL && mismatch);

  // The timer is reloaded whenever DRIVE is about to be entered.
  assign tmr_load = ((state == IDLE) && start) || ((state == SAMPLE) && !finish_now);
  assign tmr_en   = (state == DRIVE);

  settle_timer #(
    .W        (TW),
    .LOAD_VAL (SETTLE_CYC - 1)
  ) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .count_en (tmr_en),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      stim     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= '0;
      fail_idx <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= DRIVE;
            stim     <= '0;
            err_cnt  <= '0;
            fail_idx <= '0;
            pass     <= 1'b0;
            busy     <= 1'b1;
          end
        end
        DRIVE: begin
          if (tmr_expired) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (mismatch) begin
            if (err_cnt != ERR_W'(N_VEC)) begin
              err_cnt <= err_cnt + 1'b1;
            end
            if (err_cnt == '0) begin
              fail_idx <= stim;
            end
          end
          if (finish_now) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_cnt == '0) && !mismatch;
          end else begin
            stim  <= stim + 1'b1;
            state <= DRIVE;
          end
        end
        FIN: begin
          state <= IDLE;
          stim  <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_tt_checker.sv
// Scoreboard bench for gate_tt_checker: a 2-input instance with defaults and a
// 3-input OR instance; behavioural gate models drive resp.
module tb_gate_tt_checker;

  typedef struct {
    int exp_pass;
    int exp_err;
    int exp_fidx;
    int exp_busy;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] stim;
  logic       resp;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_cnt;
  logic [1:0] fail_idx;

  logic       start3;
  logic [2:0] stim3;
  logic       resp3;
  logic       busy3;
  logic       done3;
  logic       pass3;
  logic [3:0] err_cnt3;
  logic [2:0] fail_idx3;

  int   mode;
  int   n_chk;
  int   n_pass;
  exp_t sbq[$];

  gate_tt_checker dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stim     (stim),
    .resp     (resp),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_cnt  (err_cnt),
    .fail_idx (fail_idx)
  );

  gate_tt_checker #(
    .N_IN       (3),
    .EXP_TT     (8'hFE),
    .SETTLE_CYC (1)
  ) dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start3),
    .stim     (stim3),
    .resp     (resp3),
    .busy     (busy3),
    .done     (done3),
    .pass     (pass3),
    .err_cnt  (err_cnt3),
    .fail_idx (fail_idx3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode 0: OR of all inputs, 1: 2-input AND, 2: stuck-at-0
  function automatic logic gate_fn(input int m, input logic [2:0] v);
    case (m)
      0:       return |v;
      1:       return v[0] & v[1];
      default: return 1'b0;
    endcase
  endfunction

  always_comb resp  = gate_fn(mode, {1'b0, stim});
  always_comb resp3 = gate_fn(mode, stim3);

  function automatic exp_t model(input int n_in, input int settle, input logic [7:0] tt, input int m);
    exp_t r;
    int   applied;
    logic g;
    r.exp_err  = 0;
    r.exp_fidx = 0;
    applied    = 0;
    for (int v = 0; v < (1 << n_in); v++) begin
      applied++;
      g = gate_fn(m, 3'(v));
      if (g != tt[v]) begin
        if (r.exp_err == 0) r.exp_fidx = v;
        r.exp_err++;
`ifdef GATE_TT_STOP_ON_FAIL_EN
        break;
`endif
      end
    end
    r.exp_pass = (r.exp_err == 0) ? 1 : 0;
    r.exp_busy = applied * (settle + 1);
    return r;
  endfunction

  task automatic check(input string tag, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start = v;
    else start3 = v;
  endtask

  function automatic int done_of(input int sel);
    return (sel == 0) ? int'(done) : int'(done3);
  endfunction
  function automatic int busy_of(input int sel);
    return (sel == 0) ? int'(busy) : int'(busy3);
  endfunction
  function automatic int pass_of(input int sel);
    return (sel == 0) ? int'(pass) : int'(pass3);
  endfunction
  function automatic int err_of(input int sel);
    return (sel == 0) ? int'(err_cnt) : int'(err_cnt3);
  endfunction
  function automatic int fidx_of(input int sel);
    return (sel == 0) ? int'(fail_idx) : int'(fail_idx3);
  endfunction

  // Start a run, optionally poking start again mid-run, and score the result at done.
  task automatic run(input int sel, input int m, input bit poke);
    exp_t e;
    int   cyc;
    int   bcnt;
    bit   seen;
    mode = m;
    if (sel == 0) e = model(2, 2, 8'h0E, m);
    else          e = model(3, 1, 8'hFE, m);
    sbq.push_back(e);
    @(negedge clk); set_start(sel, 1'b1);
    @(negedge clk); set_start(sel, 1'b0);
    cyc  = 1;
    bcnt = 0;
    seen = 1'b0;
    while (cyc < 200) begin
      if (done_of(sel) != 0) begin
        seen = 1'b1;
        break;
      end
      if (busy_of(sel) != 0) bcnt++;
      set_start(sel, (poke && cyc == 5) ? 1'b1 : 1'b0);
      @(negedge clk);
      cyc++;
    end
    set_start(sel, 1'b0);
    check("done_seen", int'(seen), 1);
    e = sbq.pop_front();
    if (seen) begin
      check("busy_len", bcnt, e.exp_busy);
      check("done_cyc", cyc, e.exp_busy + 1);
      check("busy_at_done", busy_of(sel), 0);
      check("pass", pass_of(sel), e.exp_pass);
      check("err_cnt", err_of(sel), e.exp_err);
      check("fail_idx", fidx_of(sel), e.exp_fidx);
      repeat (3) begin
        @(negedge clk);
        check("done_pulse_1cyc", done_of(sel), 0);
        check("idle_no_rerun", busy_of(sel), 0);
      end
      check("hold_pass", pass_of(sel), e.exp_pass);
      check("hold_err", err_of(sel), e.exp_err);
      check("hold_fidx", fidx_of(sel), e.exp_fidx);
    end
  endtask

  task automatic reset_mid_run();
    int done_seen;
    mode = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_busy", int'(busy), 1);
    check("pre_rst_stim", int'(stim), 1);
    rst_n = 1'b0;
    #1;
    check("rst_stim", int'(stim), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pass", int'(pass), 0);
    check("rst_err", int'(err_cnt), 0);
    check("rst_fidx", int'(fail_idx), 0);
    @(negedge clk); rst_n = 1'b1;
    done_seen = 0;
    repeat (16) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("no_done_after_abort", done_seen, 0);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    mode   = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    start3 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_stim", int'(stim), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_pass", int'(pass), 0);
    check("reset_err", int'(err_cnt), 0);
    check("reset_fidx", int'(fail_idx), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run(0, 0, 1'b0);
    run(0, 1, 1'b0);
    run(0, 2, 1'b0);
    run(0, 0, 1'b1);
    run(0, 1, 1'b1);
    reset_mid_run();
    run(0, 0, 1'b0);
    run(1, 0, 1'b0);
    run(1, 2, 1'b0);

    check("sb_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
